// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-slave transaction controller.
//   state_e    : controller state encoding (3-bit)
//   RW_READ    : value of the R/W bit that selects a read frame
//   *_BITS_DEF : default frame geometry
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ADDR         = 3'd1,
    ADDR_LATCH   = 3'd2,
    READ_LOAD    = 3'd3,
    READ_OUT     = 3'd4,
    WRITE_GET    = 3'd5,
    WRITE_COMMIT = 3'd6,
    DONE         = 3'd7
  } state_e;

  localparam logic RW_READ = 1'b1;

  localparam int unsigned ADDR_BITS_DEF = 7;
  localparam int unsigned DATA_BITS_DEF = 8;

endpackage

// File: rtl/spi_transaction_fsm_bit_counter.sv
// Bit counter for the SPI transaction controller.
//   clk    : system clock
//   clr    : synchronous clear (wins over inc)
//   inc    : increment enable
//   limit  : terminal value to compare against
//   cnt    : current count
//   tc     : combinational (cnt == limit)
module spi_bit_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == limit);

endmodule

// File: rtl/spi_transaction_fsm.sv
// Sequencer for the SPI-slave datapath. One frame per chip-select-low
// window: ADDR_BITS address bits + R/W bit, then DATA_BITS data bits.
//   clk, reset   : clock, synchronous active-high reset
//   sclkPosEdge  : one-clk strobe per conditioned SCLK rising edge
//   sclkNegEdge  : one-clk strobe per conditioned SCLK falling edge
//   csHigh       : conditioned chip select (1 = deselected)
//   rwBit        : R/W bit from the shift register after the address phase
//   addrWe       : address latch enable pulse
//   srWe         : shift register parallel-load pulse
//   dmWe         : data memory write enable pulse
//   misoBufe     : MISO tri-state buffer enable
//   busy         : state != IDLE
module spi_transaction_fsm
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned CNT_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sclkPosEdge,
  input  logic sclkNegEdge,
  input  logic csHigh,
  input  logic rwBit,
  output logic addrWe,
  output logic srWe,
  output logic dmWe,
  output logic misoBufe,
  output logic busy
);

  state_e           state_q, state_d;
  logic             addr_we_q, addr_we_d;
  logic             sr_we_q, sr_we_d;
  logic             dm_we_q, dm_we_d;
  logic             miso_bufe_q, miso_bufe_d;
  logic             busy_q, busy_d;

  logic             cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0] cnt_limit;
  logic [CNT_W-1:0] cnt_val;

  // Terminal compare is on the count before the final edge, so the
  // counter is cleared on that edge and never holds the terminal value.
  spi_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .clr   (cnt_clr | reset),
    .inc   (cnt_inc),
    .limit (cnt_limit),
    .cnt   (cnt_val),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cnt_limit = CNT_W'(DATA_BITS - 1);
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!csHigh) state_d = ADDR;
      end
      ADDR: begin
        cnt_limit = CNT_W'(ADDR_BITS);
        if (sclkPosEdge) begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            state_d = ADDR_LATCH;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ADDR_LATCH: state_d = (rwBit == RW_READ) ? READ_LOAD : WRITE_GET;
      READ_LOAD:  state_d = READ_OUT;
      READ_OUT: begin
        if (sclkNegEdge) begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            state_d = DONE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      WRITE_GET: begin
        if (sclkPosEdge) begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            state_d = WRITE_COMMIT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      WRITE_COMMIT: state_d = DONE;
      DONE: if (csHigh) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Deselect aborts the frame and overrides any coincident counting edge.
    if (state_q != IDLE && csHigh) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
      cnt_inc = 1'b0;
    end

    // Outputs are decoded from the next state so the registered strobes
    // line up with the state they belong to.
    addr_we_d   = (state_d == ADDR_LATCH);
    sr_we_d     = (state_d == READ_LOAD);
    dm_we_d     = (state_d == WRITE_COMMIT);
    miso_bufe_d = (state_d == READ_OUT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_we_q   <= 1'b0;
      sr_we_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      miso_bufe_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_we_q   <= addr_we_d;
      sr_we_q     <= sr_we_d;
      dm_we_q     <= dm_we_d;
      miso_bufe_q <= miso_bufe_d;
      busy_q      <= busy_d;
    end
  end

  assign addrWe   = addr_we_q;
  assign srWe     = sr_we_q;
  assign dmWe     = dm_we_q;
  assign misoBufe = miso_bufe_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Directed bench for spi_transaction_fsm. Output vector order:
// {addrWe, srWe, dmWe, misoBufe, busy}.
module tb_spi_transaction_fsm;

  logic clk = 1'b0;
  logic reset, sclkPosEdge, sclkNegEdge, csHigh, rwBit;
  logic addrWe, srWe, dmWe, misoBufe, busy;

  int checks = 0;
  int errors = 0;

  // High-cycle counters, only ever incremented here; tasks take snapshots.
  int n_addr = 0, n_sr = 0, n_dm = 0, n_miso = 0;

  always #5 clk = ~clk;

  spi_transaction_fsm #(.ADDR_BITS(7), .DATA_BITS(8), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .sclkPosEdge (sclkPosEdge),
    .sclkNegEdge (sclkNegEdge),
    .csHigh      (csHigh),
    .rwBit       (rwBit),
    .addrWe      (addrWe),
    .srWe        (srWe),
    .dmWe        (dmWe),
    .misoBufe    (misoBufe),
    .busy        (busy)
  );

  always @(negedge clk) begin
    if (addrWe   === 1'b1) n_addr++;
    if (srWe     === 1'b1) n_sr++;
    if (dmWe     === 1'b1) n_dm++;
    if (misoBufe === 1'b1) n_miso++;
  end

  typedef struct {
    logic       rst, cs, pos, neg, rw;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[26];

  task automatic cyc(input logic rst, input logic cs, input logic pos,
                     input logic neg, input logic rw);
    reset = rst; csHigh = cs; sclkPosEdge = pos; sclkNegEdge = neg; rwBit = rw;
    @(posedge clk);
    #1;
    sclkPosEdge = 1'b0; sclkNegEdge = 1'b0;
  endtask

  task automatic chk(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {addrWe, srWe, dmWe, misoBufe, busy};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %05b expected %05b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Address phase: start clk plus 8 posedges (7 address + R/W) with gaps.
  task automatic addr_phase(input logic rw, input string tag);
    cyc(0, 0, 0, 0, rw);
    chk({tag, "_start"}, 5'b00001);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0, rw);
      if (i == 7) chk({tag, "_addrwe"}, 5'b10001);
      else        chk({tag, "_addr"},   5'b00001);
      if (i != 7) cyc(0, 0, 0, 0, rw);
    end
  endtask

  task automatic read_frame();
    int a0, s0, d0;
    a0 = n_addr; s0 = n_sr; d0 = n_dm;
    addr_phase(1'b1, "rd");
    cyc(0, 0, 0, 0, 1);
    chk("rd_srwe", 5'b01001);
    cyc(0, 0, 0, 0, 1);
    chk("rd_miso_on", 5'b00011);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1, 1);
      if (i == 7) chk("rd_miso_off", 5'b00001);
      else if (i == 6) chk("rd_miso_7", 5'b00011);
      if (i != 7) cyc(0, 0, 0, 0, 1);
    end
    cyc(0, 1, 0, 0, 1);
    chk("rd_end", 5'b00000);
    chk_int("rd_n_addr", n_addr - a0, 1);
    chk_int("rd_n_sr",   n_sr - s0,   1);
    chk_int("rd_n_dm",   n_dm - d0,   0);
  endtask

  // data_pos < 8 aborts with csHigh after that many data posedges.
  task automatic write_frame(input int data_pos, input int extra, input string tag);
    int a0, s0, d0, m0;
    a0 = n_addr; s0 = n_sr; d0 = n_dm; m0 = n_miso;
    addr_phase(1'b0, tag);
    cyc(0, 0, 0, 0, 0);
    chk({tag, "_get"}, 5'b00001);
    for (int i = 0; i < data_pos; i++) begin
      cyc(0, 0, 1, 0, 0);
      if (i == 7) chk({tag, "_dmwe"}, 5'b00101);
      cyc(0, 0, 0, 0, 0);
    end
    if (data_pos == 8) chk({tag, "_done"}, 5'b00001);
    for (int i = 0; i < extra; i++) begin
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0);
    end
    if (extra > 0) chk({tag, "_extra_done"}, 5'b00001);
    cyc(0, 1, 0, 0, 0);
    chk({tag, "_end"}, 5'b00000);
    cyc(0, 1, 0, 0, 0);
    chk_int({tag, "_n_addr"}, n_addr - a0, 1);
    chk_int({tag, "_n_dm"},   n_dm - d0,   (data_pos == 8) ? 1 : 0);
    chk_int({tag, "_n_sr"},   n_sr - s0,   0);
    chk_int({tag, "_n_miso"}, n_miso - m0, 0);
  endtask

  initial begin
    reset = 1'b1; csHigh = 1'b1; sclkPosEdge = 1'b0; sclkNegEdge = 1'b0; rwBit = 1'b0;
    #2;

    //         rst   cs    pos   neg   rw    exp
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00001}; // start; pos not counted
    for (int i = 3; i <= 9; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00001};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000}; // abort on 8th posedge
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001}; // negedge ignored in ADDR
    for (int i = 14; i <= 20; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00001};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b10001};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b01001};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00011};
    vecs[24] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00011}; // posedge ignored in READ_OUT
    vecs[25] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00000};

    for (int i = 0; i < 26; i++) begin
      cyc(vecs[i].rst, vecs[i].cs, vecs[i].pos, vecs[i].neg, vecs[i].rw);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset in the middle of READ_OUT, then a clean read.
    addr_phase(1'b1, "pre");
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("pre_miso", 5'b00011);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1);
    end
    cyc(1, 0, 0, 0, 1);
    chk("rst_mid", 5'b00000);
    cyc(0, 1, 0, 0, 1);
    chk("rst_after", 5'b00000);
    read_frame();

    write_frame(8, 0, "wr");
    write_frame(5, 0, "ab");
    write_frame(8, 0, "wr2");
    write_frame(8, 12, "ex");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_transaction_fsm.md
Name: spi_transaction_fsm

Overview:
- Controller that sequences the SPI-slave datapath.
- Watches the conditioned chip-select and serial-clock edge strobes and counts bits. Drives the control strobes for the address latch, the shift register parallel load, data-memory write, and the MISO tri-state buffer.
- Protocol: one frame per chip-select-low window. The frame is ADDR_BITS address bits plus one R/W bit (last bit in, 1 = read), then DATA_BITS data bits in or out.

Parameters:
- ADDR_BITS, 7, number of address bits preceding the R/W bit.
- DATA_BITS, 8, width of the data phase and of the shift register.
- CNT_W, 4, bit-counter width; must hold max(ADDR_BITS+1, DATA_BITS).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- sclkPosEdge  in  1  one-clk strobe on each conditioned SCLK rising edge; this is the shift register's peripheralClkEdge.
- sclkNegEdge  in  1  one-clk strobe on each conditioned SCLK falling edge.
- csHigh  in  1  conditioned chip select; 1 = deselected.
- rwBit  in  1  shift register parallelDataOut[0], the R/W bit after the address phase.
- addrWe  out  1  address latch enable, one-clk pulse.
- srWe  out  1  shift register parallelLoad, one-clk pulse.
- dmWe  out  1  data memory write enable, one-clk pulse.
- misoBufe  out  1  MISO output buffer enable.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state = IDLE, bit counter = 0, all outputs 0 on the next clk edge. Reset overrides all other inputs, including mid-frame.
- All outputs are registered Moore decodes of the state. Each strobe is high for exactly one clk.

States and transitions:
- IDLE: counter = 0. If csHigh == 0, go to ADDR.
- ADDR: counter increments on each sclkPosEdge. On the edge that makes the count ADDR_BITS+1, clear the counter and go to ADDR_LATCH.
- ADDR_LATCH: addrWe = 1. Sample rwBit. If 1, go to READ_LOAD; if 0, go to WRITE_GET.
- READ_LOAD: srWe = 1 for one clk, then go to READ_OUT. This gives memory one clk of read latency after addrWe.
- READ_OUT: misoBufe = 1. Counter increments on each sclkNegEdge. At count DATA_BITS, go to DONE with misoBufe dropping.
- WRITE_GET: counter increments on each sclkPosEdge. At count DATA_BITS, go to WRITE_COMMIT.
- WRITE_COMMIT: dmWe = 1 for one clk, then go to DONE.
- DONE: all strobes 0. Wait for csHigh == 1, then go to IDLE.

Boundary conditions:
- csHigh == 1 in any non-IDLE state aborts the frame:
  - IDLE on the next clk, counter cleared.
  - No addrWe/srWe/dmWe is issued for that clk or later.
  - A partially received write never produces dmWe.
- An abort takes priority over a coincident counting edge.
- sclkPosEdge in READ_OUT and sclkNegEdge in ADDR/WRITE_GET are ignored.
- Extra SCLK edges in DONE are ignored; no wrap into a second frame until csHigh has been 1.
- A frame can start in the same clk csHigh falls. A posedge strobe in that IDLE clk is not counted.
- Counter never exceeds its terminal value; it is cleared on every phase transition.

Decomposition:
- Package spi_pkg holds:
  - state encoding localparams (IDLE, ADDR, ADDR_LATCH, READ_LOAD, READ_OUT, WRITE_GET, WRITE_COMMIT, DONE; 3-bit);
  - RW_READ = 1;
  - default ADDR_BITS and DATA_BITS.
- One natural sub-module, spi_bit_counter:
  - CNT_W counter with sync clear and increment-enable;
  - combinational terminal-count compare against an input limit.

Test Plan:
- Reset mid-READ_OUT, then release → all outputs 0 and busy 0 on the first clk after reset. A new frame then proceeds normally.
- Write frame (csHigh 0; 8 posedges with address 0x15 and rwBit 0; 8 posedges of data 0xA5):
  - addrWe pulses once, one clk after the 8th posedge;
  - dmWe pulses once, one clk after the 16th posedge;
  - srWe and misoBufe stay 0.
- Read frame (address 0x2A, rwBit 1):
  - addrWe pulse, then srWe on the next clk;
  - misoBufe high from the following clk through exactly 8 sclkNegEdge strobes, then 0;
  - dmWe stays 0.
- Abort (csHigh raised after 5 data posedges of a write) → IDLE next clk, no dmWe ever, busy 0. A following full write frame commits correctly.
- Extra edges (12 posedges sent after a write frame before csHigh rises) → no additional pulses; state stays DONE until csHigh = 1, then busy 0.
- Coincidence (csHigh rises in the same clk as the 8th address posedge) → no addrWe, next state IDLE.
